seg_display_mux_seq: RTL

- Parametrised successor to the signed 7-segment display driver.
- Takes a signed two's-complement value of DATA_W bits through a load handshake.
- Converts the magnitude to BCD with an iterative double-dabble engine, one bit per clock, instead of a combinational converter.
- Time-multiplexes a sign digit plus DIGITS-1 magnitude digits onto active-low anodes and segments. Adds overflow indication and a busy flag.

---
 rtl/seg_display_mux_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_mux_seq.sv
// Signed value -> iterative double-dabble BCD -> time-multiplexed active-low 7-segment scan.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_display_mux_seq #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 4,
    parameter int DIV_W  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] num_in,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg_out
);

    function automatic int dec_digits(input int w);
        longint unsigned v;
        int              n;
        v = 64'd1 << (w - 1);
        n = 0;
        while (v != 0) begin
            n++;
            v = v / 10;
        end
        return n;
    endfunction

    function automatic logic [31:0] pow10(input int e);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < e; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam int          MAG_NIB   = DIGITS - 1;
    localparam int          MAG_W     = 4 * MAG_NIB;
    localparam int          NEED_NIB  = dec_digits(DATA_W);
    localparam int          BCD_NIB   = (NEED_NIB > MAG_NIB) ? NEED_NIB : MAG_NIB;
    localparam int          BCD_W     = 4 * BCD_NIB;
    localparam int          IDX_W     = $clog2(DIGITS);
    localparam int          CNT_W     = $clog2(DATA_W + 1);
    localparam logic [31:0] OVF_LIMIT = pow10(MAG_NIB);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b1111110;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              disp_sign_q, disp_sign_d;
    logic [MAG_W-1:0]  disp_bcd_q, disp_bcd_d;
    logic              overflow_q, overflow_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [DATA_W-1:0] mag_abs;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_shift;
    logic [MAG_NIB-1:0] lz_mask;
    logic [3:0]        cur_nib;
    logic              cur_lz;

    // Magnitude is kept unsigned in DATA_W bits so the most negative input maps onto 2^(DATA_W-1).
    assign mag_abs = num_in[DATA_W-1] ? (-num_in) : num_in;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < BCD_NIB; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                           : bcd_q[4*i +: 4];
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        disp_sign_d = disp_sign_q;
        disp_bcd_d  = disp_bcd_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = CONV;
                    sign_d     = num_in[DATA_W-1];
                    mag_d      = mag_abs;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(DATA_W);
                    ovf_pend_d = ({{(32-DATA_W){1'b0}}, mag_abs} >= OVF_LIMIT);
                end
            end
            CONV: begin
                bcd_d = bcd_shift;
                mag_d = mag_q << 1;
                cnt_d = cnt_q - 1'b1;
                // Last shift: commit straight from the shifter so display updates on this edge.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = IDLE;
                    disp_sign_d = sign_q;
                    disp_bcd_d  = bcd_shift[MAG_W-1:0];
                    overflow_d  = ovf_pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (&div_q) begin
            idx_d = (idx_q == '0) ? IDX_W'(DIGITS - 1) : (idx_q - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            disp_sign_q <= 1'b0;
            disp_bcd_q  <= '0;
            overflow_q  <= 1'b0;
            div_q       <= '0;
            idx_q       <= IDX_W'(DIGITS - 1);
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            disp_sign_q <= disp_sign_d;
            disp_bcd_q  <= disp_bcd_d;
            overflow_q  <= overflow_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic lz_run;

    // A digit is blank while every digit from the top down to it is zero; the ones digit never is.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = MAG_NIB - 1; i >= 1; i--) begin
            lz_run     = lz_run & (disp_bcd_q[4*i +: 4] == 4'd0);
            lz_mask[i] = lz_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_nib = 4'd0;
        cur_lz  = 1'b0;
        for (int i = 0; i < MAG_NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = disp_bcd_q[4*i +: 4];
                cur_lz  = lz_mask[i];
            end
        end

        anode = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);

        if (idx_q == IDX_W'(DIGITS - 1)) begin
            seg_out = disp_sign_q ? SEG_DASH : SEG_BLANK;
        end else if (overflow_q) begin
            seg_out = SEG_DASH;
        end else if (cur_lz) begin
            seg_out = SEG_BLANK;
        end else begin
            seg_out = seg_decode(cur_nib);
        end
    end

    assign busy     = (state_q == CONV);
    assign overflow = overflow_q;

endmodule
